// File: rtl/line_memory_ctrl.sv
// rtl/line_memory_ctrl.sv - line-wide backing memory with fixed access latency
// One request in flight; bytes written or a line read on the final latency edge.
module line_memory_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LINE_W-1:0]   data_i,
  input  logic [LINE_W/8-1:0] be_i,
  input  logic                enable_i,
  input  logic                write_i,
  output logic                ready_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [LINE_W-1:0]   data_o
);

  localparam int NB     = LINE_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              wr_q;
  logic              in_range;
  logic              fire;

  logic [LINE_W-1:0] mem [DEPTH];

  // Byte offset bits never select anything inside the line.
  generate
    if (OFF_W > 0) begin : g_off
      logic unused_offset;
      assign unused_offset = ^addr_i[OFF_W-1:0];
    end
  endgenerate

  assign ready_o  = (state == IDLE);
  assign in_range = ({1'b0, idx_q} < DEPTH_L);
  assign fire     = (state == BUSY) && (count == LAST);

  // Out-of-range writes are dropped rather than folded onto a truncated index.
  always_ff @(posedge clk_i) begin
    if (fire && wr_q && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) mem[idx_q[MEM_AW-1:0]][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      count   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            idx_q   <= addr_i[ADDR_W-1:OFF_W];
            wdata_q <= data_i;
            be_q    <= be_i;
            wr_q    <= write_i;
            count   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (count == LAST) begin
            ack_o <= 1'b1;
            err_o <= !in_range;
            if (!wr_q) data_o <= in_range ? mem[idx_q[MEM_AW-1:0]] : '0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_memory_ctrl.sv
// tb/tb_line_memory_ctrl.sv - randomized self-checking bench for line_memory_ctrl
`timescale 1ns/1ps
module tb_line_memory_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] data = '0;
  logic [31:0]  be = '0;
  logic         en = 1'b0, wr = 1'b0;
  logic         ready, ack, err;
  logic [255:0] dout;

  logic [31:0]  s_addr = '0;
  logic [127:0] s_data = '0;
  logic [15:0]  s_be = '0;
  logic         s_en = 1'b0, s_wr = 1'b0;
  logic         s_ready, s_ack, s_err;
  logic [127:0] s_dout;

  int tests = 0;
  int fails = 0;
  logic [255:0] ref_mem [int];

  always #5 clk = ~clk;

  line_memory_ctrl dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data), .be_i(be),
    .enable_i(en), .write_i(wr), .ready_o(ready), .ack_o(ack), .err_o(err), .data_o(dout)
  );

  line_memory_ctrl #(.LINE_W(128), .DEPTH(16), .ADDR_W(32), .LATENCY(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .addr_i(s_addr), .data_i(s_data), .be_i(s_be),
    .enable_i(s_en), .write_i(s_wr), .ready_o(s_ready), .ack_o(s_ack), .err_o(s_err),
    .data_o(s_dout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] o, input logic [255:0] n,
                                         input logic [31:0] b);
    logic [255:0] r;
    r = o;
    for (int k = 0; k < 32; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  // Issue one request, scramble inputs while busy, return cycles from accept to ack.
  task automatic op(input logic w, input logic [31:0] a, input logic [255:0] d,
                    input logic [31:0] b, output logic [255:0] rd, output logic e,
                    output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin @(posedge clk); #1; guard++; end
    addr = a; data = d; be = b; wr = w; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; addr = $urandom; data = rnd256(); be = $urandom; wr = $urandom_range(0, 1);
    lat = 0; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; rd = dout; e = err; break; end
      if (i == 50) lat = 99;
    end
  endtask

  task automatic op_s(input logic w, input logic [31:0] a, input logic [127:0] d,
                      output logic [127:0] rd, output logic e, output int lat);
    s_addr = a; s_data = d; s_be = '1; s_wr = w; s_en = 1'b1;
    @(posedge clk); #1;
    s_en = 1'b0; s_addr = $urandom; s_data = rnd256()[127:0]; s_wr = $urandom_range(0, 1);
    lat = 99; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (s_ack) begin lat = i; rd = s_dout; e = s_err; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (dout !== '0) begin fails++; $display("FAIL reset_data got %h want 0", dout); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [255:0] rd; logic e; int lat; logic [255:0] pat;
    pat = {32{8'hA5}};
    op(1'b1, 32'h20, pat, '1, rd, e, lat);
    ref_mem[1] = pat;
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_wr_latency got %0d want 8", lat); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_wr_err got %b want 0", e); end
    op(1'b0, 32'h20, '0, '0, rd, e, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_rd_latency got %0d want 8", lat); end
    tests++; if (rd !== pat) begin fails++; $display("FAIL basic_rd_data got %h want %h", rd, pat); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_rd_err got %b want 0", e); end
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL basic_ack_pulse got %b want 0", ack); end
    tests++; if (dout !== pat) begin fails++; $display("FAIL basic_data_hold got %h want %h", dout, pat); end
  endtask

  task automatic test_byte_enable();
    logic [255:0] rd; logic e; int lat; logic [255:0] want;
    op(1'b1, 32'h40, '0, '1, rd, e, lat);
    op(1'b1, 32'h40, '1, 32'h1, rd, e, lat);
    want = 256'hFF;
    ref_mem[2] = want;
    tests++; if (dout !== {32{8'hA5}}) begin fails++; $display("FAIL be_write_keeps_data got %h", dout); end
    op(1'b0, 32'h40, '0, '0, rd, e, lat);
    tests++; if (rd !== want) begin fails++; $display("FAIL be_byte0 got %h want %h", rd, want); end
    op(1'b1, 32'h40, '1, 32'h0, rd, e, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL be_zero_ack got %0d want 8", lat); end
    op(1'b0, 32'h40, '0, '0, rd, e, lat);
    tests++; if (rd !== want) begin fails++; $display("FAIL be_zero_nochange got %h want %h", rd, want); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] r; int c1, c2;
    r = rnd256();
    addr = 32'h60; data = r; be = '1; wr = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    addr = 32'h60; wr = 1'b0; data = rnd256(); be = $urandom;
    c1 = 0;
    while (!ack && c1 < 50) begin @(posedge clk); #1; c1++; end
    tests++; if (c1 !== 8) begin fails++; $display("FAIL b2b_first_latency got %0d want 8", c1); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_in_ack got %b want 1", ready); end
    @(posedge clk); #1;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept got ready %b want 0", ready); end
    en = 1'b0; addr = $urandom; data = rnd256(); wr = 1'b1; be = '1;
    c2 = 1;
    while (!ack && c2 < 50) begin @(posedge clk); #1; c2++; end
    ref_mem[3] = r;
    tests++; if (c2 !== 9) begin fails++; $display("FAIL b2b_ack_spacing got %0d want 9", c2); end
    tests++; if (dout !== r) begin fails++; $display("FAIL b2b_read_data got %h want %h", dout, r); end
  endtask

  task automatic test_out_of_range();
    logic [255:0] rd; logic e; int lat; logic [255:0] z;
    z = rnd256();
    op(1'b1, 32'h0, z, '1, rd, e, lat);
    ref_mem[0] = z;
    op(1'b1, 32'd16384, ~z, '1, rd, e, lat);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_write_err got %b want 1", e); end
    op(1'b0, 32'd16384, '0, '0, rd, e, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL oor_read_latency got %0d want 8", lat); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_read_err got %b want 1", e); end
    tests++; if (rd !== '0) begin fails++; $display("FAIL oor_read_data got %h want 0", rd); end
    @(posedge clk); #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL oor_err_after_ack got %b want 0", err); end
    op(1'b0, 32'h0, '0, '0, rd, e, lat);
    tests++; if (rd !== z) begin fails++; $display("FAIL oor_no_alias got %h want %h", rd, z); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL oor_inrange_err got %b want 0", e); end
  endtask

  task automatic test_reset_mid_busy();
    logic [255:0] rd; logic e; int lat; logic [255:0] old_d; int acks;
    old_d = rnd256();
    op(1'b1, 32'hA0, old_d, '1, rd, e, lat);
    op(1'b0, 32'hA0, '0, '0, rd, e, lat);
    addr = 32'hA0; data = ~old_d; be = '1; wr = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", ready); end
    tests++; if (dout !== '0) begin fails++; $display("FAIL midrst_data got %h want 0", dout); end
    @(posedge clk); #1; rst = 1'b1;
    acks = 0;
    repeat (12) begin @(posedge clk); #1; if (ack) acks++; end
    tests++; if (acks !== 0) begin fails++; $display("FAIL midrst_no_ack got %0d acks want 0", acks); end
    op(1'b0, 32'hA0, '0, '0, rd, e, lat);
    ref_mem[5] = old_d;
    tests++; if (rd !== old_d) begin fails++; $display("FAIL midrst_old_data got %h want %h", rd, old_d); end
  endtask

  task automatic test_random();
    logic [255:0] rd, d; logic e; int lat; int idx; logic [31:0] b; logic w; logic inr;
    for (int i = 0; i < 16; i++) begin
      d = rnd256();
      op(1'b1, i * 32, d, '1, rd, e, lat);
      ref_mem[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? 512 + $urandom_range(0, 20) : $urandom_range(0, 15);
      inr = (idx < 512);
      w = $urandom_range(0, 1);
      d = rnd256(); b = $urandom;
      op(w, idx * 32 + $urandom_range(0, 31), d, b, rd, e, lat);
      tests++; if (lat !== 8 || e !== !inr) begin
        fails++; $display("FAIL rand_ack op %0d got lat %0d err %b want 8 %b", n, lat, e, !inr);
      end
      if (w && inr) ref_mem[idx] = merge(ref_mem[idx], d, b);
      if (!w) begin
        tests++; if (rd !== (inr ? ref_mem[idx] : 256'b0)) begin
          fails++; $display("FAIL rand_read op %0d idx %0d got %h", n, idx, rd);
        end
      end
    end
  endtask

  task automatic test_small();
    logic [127:0] rd, d; logic e; int lat;
    d = rnd256()[127:0];
    op_s(1'b1, 32'h30, d, rd, e, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL small_wr_latency got %0d want 1", lat); end
    op_s(1'b0, 32'h30, '0, rd, e, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL small_rd_latency got %0d want 1", lat); end
    tests++; if (rd !== d) begin fails++; $display("FAIL small_rd_data got %h want %h", rd, d); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL small_rd_err got %b want 0", e); end
    op_s(1'b0, 32'd256, '0, rd, e, lat);
    tests++; if (e !== 1'b1 || rd !== '0) begin
      fails++; $display("FAIL small_oor got err %b data %h want 1 0", e, rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_busy();
    test_random();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
